// File: rtl/fx_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-add-3). One input bit per clock.
// Define FX_BCD_BLANK_EN to blank leading zero digits (4'hF) when bcd_out is loaded.

module fx_bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

module fx_bcd_converter #(
  parameter int BIN_W  = 22,
  parameter int DIGITS = 7
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic [BIN_W-1:0]      data_fx,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  out_valid,
  output logic                  busy
);
  localparam int SW    = 4*DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W-1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

`ifdef FX_BCD_BLANK_EN
  localparam logic [SW-1:0] BCD_RST = {{(DIGITS-1){4'hF}}, 4'h0};

  // Digits above the most significant nonzero digit become 4'hF; units digit always shown.
  function automatic logic [SW-1:0] blank_lead(input logic [SW-1:0] v);
    logic lead;
    blank_lead = v;
    lead = 1'b1;
    for (int i = DIGITS-1; i > 0; i--) begin
      if (lead && v[4*i +: 4] == 4'd0) blank_lead[4*i +: 4] = 4'hF;
      else lead = 1'b0;
    end
  endfunction
`else
  localparam logic [SW-1:0] BCD_RST = '0;
`endif

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [SW-1:0]    scratch;
  logic [SW-1:0]    adj;
  logic [SW-1:0]    nxt_scratch;
  logic [SW-1:0]    load_val;
  logic [BIN_W-1:0] shreg;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dig
      fx_bcd_add3 u_add3 (.din(scratch[4*g +: 4]), .dout(adj[4*g +: 4]));
    end
  endgenerate

  assign nxt_scratch = (adj << 1) | SW'(shreg[BIN_W-1]);

`ifdef FX_BCD_BLANK_EN
  assign load_val = blank_lead(nxt_scratch);
`else
  assign load_val = nxt_scratch;
`endif

  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      scratch   <= '0;
      shreg     <= '0;
      bcd_out   <= BCD_RST;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            shreg   <= data_fx;
            scratch <= '0;
            cnt     <= '0;
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          scratch <= nxt_scratch;
          shreg   <= shreg << 1;
          cnt     <= cnt + 1'b1;
          // Result is published in one shot so bcd_out is never seen half-built.
          if (cnt == CNT_LAST) begin
            bcd_out   <= load_val;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fx_bcd_converter.sv
// Bench for fx_bcd_converter: countdown/arithmetic model checked every cycle plus directed literals.
module tb_fx_bcd_converter;
  localparam int BIN_W  = 22;
  localparam int DIGITS = 7;
  localparam int SW     = 4*DIGITS;
`ifdef FX_BCD_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif
  localparam logic [SW-1:0] RST_BCD = BLANK ? {{(DIGITS-1){4'hF}}, 4'h0} : '0;

  logic              sys_clk, rst, in_valid, in_ready, out_valid, busy;
  logic [BIN_W-1:0]  data_fx;
  logic [SW-1:0]     bcd_out;

  fx_bcd_converter #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .sys_clk(sys_clk), .rst(rst), .data_fx(data_fx), .in_valid(in_valid),
    .in_ready(in_ready), .bcd_out(bcd_out), .out_valid(out_valid), .busy(busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks = 0, errors = 0, cyc = 0, m_rem = 0, ov_n = 0;
  bit started = 1'b0;
  logic [SW-1:0] m_bcd, m_pend;
  int acc_q[$], ov_cyc_q[$];
  logic [SW-1:0] got_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [SW-1:0] model_bcd(input int unsigned v);
    logic [SW-1:0] r;
    bit seen;
    int unsigned x;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    if (BLANK) begin
      seen = 1'b0;
      for (int i = DIGITS-1; i > 0; i--) begin
        if (r[4*i +: 4] != 4'd0) seen = 1'b1;
        else if (!seen) r[4*i +: 4] = 4'hF;
      end
    end
    return r;
  endfunction

  function automatic logic [SW-1:0] sel(input logic [SW-1:0] plain, input logic [SW-1:0] blanked);
    return BLANK ? blanked : plain;
  endfunction

  // m_rem counts cycles of busy remaining; DONE is the cycle where it reads 1.
  always @(posedge sys_clk) begin
    cyc     <= cyc + 1;
    started <= 1'b1;
    if (rst) begin
      m_rem <= 0;
      m_bcd <= RST_BCD;
    end else if (m_rem == 0) begin
      if (in_valid) begin
        m_rem  <= BIN_W + 1;
        m_pend <= model_bcd(32'(data_fx));
      end
    end else begin
      m_rem <= m_rem - 1;
      if (m_rem == 2) m_bcd <= m_pend;
    end
  end

  always @(negedge sys_clk) begin
    if (started) begin
      chk("in_ready", 32'(in_ready), 32'(m_rem == 0));
      chk("busy", 32'(busy), 32'(m_rem != 0));
      chk("out_valid", 32'(out_valid), 32'(m_rem == 1));
      chk("bcd_out", 32'(bcd_out), 32'(m_bcd));
      if (in_ready && in_valid && !rst) acc_q.push_back(cyc + 1);
      if (out_valid) begin
        got_q.push_back(bcd_out);
        ov_cyc_q.push_back(cyc);
        ov_n++;
      end
    end
  end

  task automatic wait_accept();
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge sys_clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge sys_clk); #2;
  endtask

  task automatic wait_idle(output int busy_n);
    bit ok = 1'b0;
    busy_n = 0;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(negedge sys_clk);
      if (busy) busy_n++;
      else ok = 1'b1;
    end
    if (!ok) chk("idle_timeout", 0, 1);
    @(posedge sys_clk); #2;
  endtask

  task automatic conv(input logic [BIN_W-1:0] v, output int busy_n);
    data_fx = v;
    in_valid = 1'b1;
    wait_accept();
    in_valid = 1'b0;
    wait_idle(busy_n);
  endtask

  initial begin
    int bn, n0, a0;
    rst = 1'b1; in_valid = 1'b0; data_fx = '0;
    repeat (2) @(posedge sys_clk);
    #2 rst = 1'b0;
    @(negedge sys_clk);
    chk("reset_bcd", 32'(bcd_out), 32'(sel(28'h0000000, 28'hFFFFFF0)));
    chk("reset_ready", 32'(in_ready), 1);
    chk("reset_busy", 32'(busy), 0);
    @(posedge sys_clk); #2;

    conv(22'd0, bn);
    chk("zero_result", 32'(got_q[$]), 32'(sel(28'h0000000, 28'hFFFFFF0)));
    chk("zero_latency", 32'(ov_cyc_q[$] - acc_q[$]), 22);

    conv(22'd4194303, bn);
    chk("full_result", 32'(got_q[$]), 32'h4194303);
    chk("full_busy_cycles", 32'(bn), 23);

    conv(22'd1234567, bn);
    chk("blank_a", 32'(got_q[$]), 32'h1234567);
    conv(22'd50, bn);
    chk("blank_b", 32'(got_q[$]), 32'(sel(28'h0000050, 28'hFFFFF50)));

    n0 = got_q.size(); a0 = acc_q.size();
    data_fx = 22'd100; in_valid = 1'b1;
    wait_accept(); data_fx = 22'd200;
    wait_accept(); data_fx = 22'd300;
    wait_accept(); in_valid = 1'b0;
    wait_idle(bn);
    chk("b2b_count", 32'(got_q.size() - n0), 3);
    chk("b2b_r0", 32'(got_q[n0]), 32'(sel(28'h0000100, 28'hFFFF100)));
    chk("b2b_r1", 32'(got_q[n0+1]), 32'(sel(28'h0000200, 28'hFFFF200)));
    chk("b2b_r2", 32'(got_q[n0+2]), 32'(sel(28'h0000300, 28'hFFFF300)));
    chk("b2b_gap0", 32'(acc_q[a0+1] - acc_q[a0]), 24);
    chk("b2b_gap1", 32'(acc_q[a0+2] - acc_q[a0+1]), 24);

    a0 = acc_q.size();
    data_fx = 22'd777; in_valid = 1'b1;
    wait_accept();
    data_fx = 22'd999;
    repeat (10) @(posedge sys_clk);
    #2 in_valid = 1'b0;
    wait_idle(bn);
    chk("shift_ignore_result", 32'(got_q[$]), 32'(sel(28'h0000777, 28'hFFFF777)));
    chk("shift_ignore_accepts", 32'(acc_q.size() - a0), 1);

    n0 = ov_n;
    data_fx = 22'd12345; in_valid = 1'b1;
    wait_accept();
    in_valid = 1'b0;
    repeat (9) @(posedge sys_clk);
    #2 rst = 1'b1;
    @(posedge sys_clk); #2 rst = 1'b0;
    @(negedge sys_clk);
    chk("midrst_bcd", 32'(bcd_out), 32'(RST_BCD));
    chk("midrst_ready", 32'(in_ready), 1);
    repeat (30) @(negedge sys_clk);
    chk("midrst_no_pulse", 32'(ov_n - n0), 0);
    @(posedge sys_clk); #2;
    conv(22'd12345, bn);
    chk("midrst_redo", 32'(got_q[$]), 32'(sel(28'h0012345, 28'hFF12345)));

    repeat (3) @(posedge sys_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
